// File: rtl/adsr_envelope_if.sv
// Control, configuration and envelope output bundle for adsr_envelope.
// en/start/stop are single-cycle strobes sampled on every clk; there is no backpressure.
interface adsr_envelope_if #(
  parameter int ACC_WIDTH = 32,
  parameter int ENV_WIDTH = 16
);
  logic                 en;
  logic                 start;
  logic                 stop;
  logic [ACC_WIDTH-1:0] attack_step;
  logic [ACC_WIDTH-1:0] decay_step;
  logic [ACC_WIDTH-1:0] sustain_level;
  logic [31:0]          sustain_time;
  logic [ACC_WIDTH-1:0] release_step;
  logic [ENV_WIDTH-1:0] env;
  logic                 busy;
  logic                 done_tick;
  logic [2:0]           state_dbg;

  modport master (
    output en, start, stop, attack_step, decay_step, sustain_level,
           sustain_time, release_step,
    input  env, busy, done_tick, state_dbg
  );

  modport slave (
    input  en, start, stop, attack_step, decay_step, sustain_level,
           sustain_time, release_step,
    output env, busy, done_tick, state_dbg
  );
endinterface

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope generator feeding the DDFS Q2.14 envelope input.
// One amplitude step per en tick; start/stop act on every clk.
module adsr_envelope #(
  parameter int ACC_WIDTH = 32,
  parameter int ENV_WIDTH = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  adsr_envelope_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {2'b01, {(ACC_WIDTH-2){1'b0}}};

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [31:0]          sus_cnt;
  logic                 busy_q;
  logic                 done_q;

  logic [ACC_WIDTH-1:0] sl;
  logic [ACC_WIDTH:0]   attack_sum;
  logic [ACC_WIDTH:0]   decay_floor;

  // One extra bit on the sums keeps the compares exact even for huge step values.
  assign sl          = (bus.sustain_level > ACC_MAX) ? ACC_MAX : bus.sustain_level;
  assign attack_sum  = {1'b0, acc} + {1'b0, bus.attack_step};
  assign decay_floor = {1'b0, sl} + {1'b0, bus.decay_step};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      acc     <= '0;
      sus_cnt <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.start) begin
        // Retrigger keeps acc so the new attack starts from the current level.
        state  <= ST_ATTACK;
        busy_q <= 1'b1;
      end else if (bus.stop && (state == ST_ATTACK || state == ST_DECAY ||
                                state == ST_SUSTAIN)) begin
        state <= ST_RELEASE;
      end else if (bus.en) begin
        case (state)
          ST_ATTACK: begin
            if (bus.attack_step == '0 || attack_sum >= {1'b0, ACC_MAX}) begin
              acc   <= ACC_MAX;
              state <= ST_DECAY;
            end else begin
              acc <= attack_sum[ACC_WIDTH-1:0];
            end
          end
          ST_DECAY: begin
            if (bus.decay_step == '0 || {1'b0, acc} <= decay_floor) begin
              acc     <= sl;
              sus_cnt <= bus.sustain_time;
              state   <= ST_SUSTAIN;
            end else begin
              acc <= acc - bus.decay_step;
            end
          end
          ST_SUSTAIN: begin
            // An all-ones count never decrements, so it means hold until stop.
            if (sus_cnt != '1) begin
              if (sus_cnt == '0) state <= ST_RELEASE;
              else               sus_cnt <= sus_cnt - 32'd1;
            end
          end
          ST_RELEASE: begin
            if (bus.release_step == '0 || acc <= bus.release_step) begin
              acc    <= '0;
              state  <= ST_IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              acc <= acc - bus.release_step;
            end
          end
          ST_IDLE: ;
          default: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.env       = acc[ACC_WIDTH-1 -: ENV_WIDTH];
  assign bus.busy      = busy_q;
  assign bus.done_tick = done_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: directed ADSR scenarios plus random notes against
// an envelope-trajectory model built segment by segment.
module tb_adsr_envelope;
  localparam int     AW  = 32;
  localparam int     EW  = 16;
  localparam longint MAX = 64'h4000_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  adsr_envelope_if #(.ACC_WIDTH(AW), .ENV_WIDTH(EW)) bus ();

  adsr_envelope #(.ACC_WIDTH(AW), .ENV_WIDTH(EW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_q[$];
  longint        m_acc;
  longint        p_a, p_d, p_sl, p_r;
  logic [31:0]   p_st;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] env_of(input longint a);
    return EW'(a >> (AW - EW));
  endfunction

  function automatic longint sl_clip();
    return (p_sl > MAX) ? MAX : p_sl;
  endfunction

  task automatic set_params(input longint a, input longint d, input longint sl,
                            input logic [31:0] st, input longint r);
    p_a = a; p_d = d; p_sl = sl; p_st = st; p_r = r;
    bus.attack_step   = p_a[AW-1:0];
    bus.decay_step    = p_d[AW-1:0];
    bus.sustain_level = p_sl[AW-1:0];
    bus.sustain_time  = p_st;
    bus.release_step  = p_r[AW-1:0];
  endtask

  // Expected-envelope generators: each appends one value per en tick.
  function automatic void gen_attack(input int max_ticks);
    for (int i = 0; i < max_ticks; i++) begin
      if (p_a == 0 || m_acc + p_a >= MAX) begin
        m_acc = MAX;
        exp_q.push_back(env_of(m_acc));
        break;
      end
      m_acc += p_a;
      exp_q.push_back(env_of(m_acc));
    end
  endfunction

  function automatic void gen_decay();
    for (int i = 0; i < 1000; i++) begin
      if (p_d == 0 || m_acc <= sl_clip() + p_d) begin
        m_acc = sl_clip();
        exp_q.push_back(env_of(m_acc));
        break;
      end
      m_acc -= p_d;
      exp_q.push_back(env_of(m_acc));
    end
  endfunction

  function automatic void gen_sustain();
    for (int i = 0; i <= int'(p_st); i++) exp_q.push_back(env_of(m_acc));
  endfunction

  function automatic void gen_release(input int max_ticks);
    for (int i = 0; i < max_ticks; i++) begin
      if (p_r == 0 || m_acc <= p_r) begin
        m_acc = 0;
        exp_q.push_back(env_of(m_acc));
        break;
      end
      m_acc -= p_r;
      exp_q.push_back(env_of(m_acc));
    end
  endfunction

  task automatic en_tick();
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic p);
    @(negedge clk);
    bus.start = s;
    bus.stop  = p;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic drain(input bit ends_idle);
    while (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      bit            last;
      en_tick();
      e    = exp_q.pop_front();
      last = ends_idle && (exp_q.size() == 0);
      chk("env", 32'(bus.env), 32'(e));
      chk("busy", 32'(bus.busy), 32'(!last));
      chk("done_tick", 32'(bus.done_tick), 32'(last));
    end
    if (ends_idle) begin
      @(posedge clk);
      #1;
      chk("done_clear", 32'(bus.done_tick), 32'd0);
      chk("busy_idle", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    set_params(0, 0, 0, 0, 0);
    m_acc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_env", 32'(bus.env), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done_tick), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Full ADSR
    set_params(64'h0400_0000, 64'h0200_0000, 64'h2000_0000, 32'd3, 64'h0100_0000);
    pulse(1'b1, 1'b0);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    gen_attack(1000); drain(0);
    chk("t1_peak", 32'(bus.env), 32'h4000);
    gen_decay(); drain(0);
    chk("t1_sustain", 32'(bus.env), 32'h2000);
    gen_sustain(); gen_release(1000); drain(1);
    chk("t1_end", 32'(bus.env), 32'h0000);

    // Hold until note-off
    set_params(64'h0400_0000, 64'h0200_0000, 64'h2000_0000, 32'hFFFF_FFFF, 64'h0100_0000);
    pulse(1'b1, 1'b0);
    gen_attack(1000); gen_decay(); drain(0);
    for (int i = 0; i < 100; i++) begin
      en_tick();
      chk("t2_hold_env", 32'(bus.env), 32'h2000);
      chk("t2_hold_busy", 32'(bus.busy), 32'd1);
    end
    pulse(1'b0, 1'b1);
    gen_release(1000); drain(1);

    // Early note-off, then retrigger mid-release
    set_params(64'h0400_0000, 64'h0200_0000, 64'h2000_0000, 32'd3, 64'h0100_0000);
    pulse(1'b1, 1'b0);
    gen_attack(5); drain(0);
    chk("t3_stop_at", 32'(bus.env), 32'h1400);
    pulse(1'b0, 1'b1);
    gen_release(10); drain(0);
    chk("t3_retrig_at", 32'(bus.env), 32'h0A00);
    pulse(1'b1, 1'b0);
    chk("t3_retrig_keep", 32'(bus.env), 32'h0A00);
    gen_attack(1000); drain(0);
    chk("t3_peak", 32'(bus.env), 32'h4000);
    pulse(1'b0, 1'b1);
    gen_release(1000); drain(1);

    // Attack saturation and sustain clipping
    set_params(64'h3000_0000, 64'h0100_0000, 64'h7000_0000, 32'd0, 64'h1000_0000);
    pulse(1'b1, 1'b0);
    gen_attack(1000); drain(0);
    chk("t4_clamp", 32'(bus.env), 32'h4000);
    gen_decay(); drain(0);
    chk("t4_sl_clip", 32'(bus.env), 32'h4000);
    gen_sustain(); gen_release(1000); drain(1);

    // Zero steps, start+stop together from IDLE
    set_params(0, 0, 64'h1800_0000, 32'd0, 0);
    pulse(1'b1, 1'b1);
    chk("t5_start_wins", 32'(bus.busy), 32'd1);
    gen_attack(1000); drain(0);
    chk("t5_attack", 32'(bus.env), 32'h4000);
    gen_decay(); drain(0);
    chk("t5_decay", 32'(bus.env), 32'h1800);
    gen_sustain(); gen_release(1000); drain(1);

    // Asynchronous reset mid-decay
    set_params(64'h0400_0000, 64'h0400_0000, 64'h1000_0000, 32'd3, 64'h0100_0000);
    pulse(1'b1, 1'b0);
    gen_attack(1000);
    for (int i = 0; i < 4; i++) begin
      m_acc -= p_d;
      exp_q.push_back(env_of(m_acc));
    end
    drain(0);
    chk("t6_pre", 32'(bus.env), 32'h3000);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_env", 32'(bus.env), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("t6_no_done", 32'(bus.done_tick), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_acc = 0;

    // Random notes
    for (int n = 0; n < 12; n++) begin
      longint a, d, r, sl;
      a  = ($urandom_range(0, 7) == 0) ? 0 : MAX / longint'($urandom_range(2, 20)) + longint'($urandom_range(0, 16'hFFFF));
      d  = ($urandom_range(0, 7) == 0) ? 0 : MAX / longint'($urandom_range(2, 20)) + longint'($urandom_range(0, 16'hFFFF));
      r  = ($urandom_range(0, 7) == 0) ? 0 : MAX / longint'($urandom_range(2, 20)) + longint'($urandom_range(0, 16'hFFFF));
      sl = longint'($urandom_range(0, 32'h7FFF_FFFF));
      set_params(a, d, sl, 32'($urandom_range(0, 4)), r);
      pulse(1'b1, ($urandom_range(0, 3) == 0));
      gen_attack(1000); gen_decay(); gen_sustain(); gen_release(1000);
      drain(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Envelope generator that sits directly upstream of the DDFS and drives its 16-bit Q2.14 envelope input.
- Produces an attack/decay/sustain/release amplitude contour in response to note-on (start) and note-off (stop) pulses.
- Advances one step per sample tick, using the same en strobe that clocks the DDFS.
- All rates and levels are run-time inputs, so a host or sequencer can reprogram the envelope per note.

Parameters:
- ACC_WIDTH, 32: internal amplitude accumulator width. Full scale (1.0) = 2^(ACC_WIDTH-2).
- ENV_WIDTH, 16: output width. env = acc[ACC_WIDTH-1:ACC_WIDTH-ENV_WIDTH], giving Q2.14 with 1.0 = 0x4000.

Ports:
- clk  in  1: system clock.
- reset_n  in  1: asynchronous active-low reset.
- en  in  1: sample tick; one amplitude step per cycle with en=1.
- start  in  1: note-on pulse.
- stop  in  1: note-off pulse.
- attack_step  in  ACC_WIDTH: increment per tick during ATTACK.
- decay_step  in  ACC_WIDTH: decrement per tick during DECAY.
- sustain_level  in  ACC_WIDTH: sustain accumulator level; values above MAX are clipped to MAX.
- sustain_time  in  32: sustain length in ticks; all-ones = hold until stop.
- release_step  in  ACC_WIDTH: decrement per tick during RELEASE.
- env  out  ENV_WIDTH: Q2.14 envelope, registered.
- busy  out  1: state != IDLE.
- done_tick  out  1: one-cycle pulse on RELEASE->IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous, active-low.
- Reset values: state=IDLE, acc=0, sustain counter=0. Outputs env=0, busy=0, done_tick=0.
- MAX = 2^(ACC_WIDTH-2) (0x4000_0000 at default); SL = min(sustain_level, MAX).
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- start/stop timing: sampled every clk, independent of en. They change state at that edge; acc is not modified by them.
- start: from any state -> ATTACK. acc is retained (retrigger without click).
- stop: ATTACK/DECAY/SUSTAIN -> RELEASE; ignored in IDLE and RELEASE.
- start and stop in the same cycle: start wins.
- Amplitude updates happen only on edges with en=1 and no start/stop in that cycle. Step inputs are read live at each en.
- ATTACK:
  - If attack_step==0 or acc+attack_step >= MAX (compute at ACC_WIDTH+1 bits): acc=MAX, -> DECAY.
  - Else acc += attack_step.
- DECAY:
  - If decay_step==0 or acc <= SL+decay_step (compute at ACC_WIDTH+1 bits): acc=SL, -> SUSTAIN.
  - Else acc -= decay_step.
  - The counter is loaded with sustain_time on entry to SUSTAIN.
- SUSTAIN:
  - acc is held.
  - If the loaded value was all-ones, remain until stop.
  - Otherwise each en: if counter==0 -> RELEASE, else decrement. Hence sustain_time=N gives N+1 en ticks in SUSTAIN.
- RELEASE:
  - If release_step==0 or acc <= release_step: acc=0, -> IDLE, and done_tick=1 for that one cycle.
  - Else acc -= release_step.
- IDLE: acc is held at its value (0 after a normal release); en has no effect.
- Latency:
  - env reflects acc after the edge that applied the en step.
  - The DDFS sampling env on the same en therefore uses the previous tick's envelope; this one-sample lag is accepted.
- busy is registered and tracks the state register.
- No arithmetic path may wrap. acc stays within [0, MAX] under all inputs.
- Reset mid-note: immediate return to reset values; no done_tick is emitted.

Test Plan:
1. Full ADSR: attack_step=0x0400_0000, decay_step=0x0200_0000, sustain_level=0x2000_0000, sustain_time=3, release_step=0x0100_0000; start then en every 4 clks.
   - Attack: env 0x0400, 0x0800, ... 0x4000 on the 16th tick, then DECAY.
   - Decay: 16 ticks down to 0x2000.
   - Sustain: env=0x2000 for 4 ticks.
   - Release: 32 ticks down to 0x0000, then done_tick=1 for one clk and busy=0.
2. Hold and note-off: sustain_time=0xFFFF_FFFF, otherwise as test 1. env holds 0x2000 for 100 ticks; stop -> RELEASE, reaching 0 after 32 ticks.
3. Early note-off and retrigger:
   - stop at attack tick 5 (env=0x1400): release continues from 0x1400 downward.
   - start at env=0x0A00: ATTACK resumes from 0x0A00, reaching 0x4000 after 14 ticks.
4. Saturation and clipping:
   - attack_step=0x3000_0000: env 0x3000, then 0x4000 (clamped, no wrap).
   - sustain_level=0x7000_0000: decay ends at env=0x4000.
5. Zero steps and simultaneous pulses:
   - All steps=0: one en each for attack (env=0x4000), decay (env=SL), and release (env=0).
   - start+stop in the same cycle from IDLE: enters ATTACK.
6. Reset mid-DECAY (env=0x3000): reset_n low asynchronously -> env=0, busy=0 before the next clk edge; no done_tick.
